// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants for the iterative multiply/divide unit:
//               ALU-decoder operation codes, FSM state encoding, datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int XLEN = 32;

    // alucontrol codes handled by the multiply/divide unit
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1a;
    localparam logic [5:0] OP_DIVU  = 6'h1b;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MTLO  = 6'h13;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] FIX  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_signfix
// Description : Conditional two's-complement negation. Driving i_neg with the
//               operand sign bit yields the absolute value; driving it with a
//               result-sign flag restores the signed result.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_dout
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    assign o_dout = i_neg ? ((~i_din) + c_one) : i_din;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 multiply/divide unit for the EX stage.
//               mult/multu/div/divu run for XLEN steps plus a sign-fix cycle
//               and update HI/LO atomically; mthi/mtlo write in one cycle.
//               Optional macro MULDIV_EARLY_OUT_EN: multiplies stop iterating
//               once the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [5:0]      alucontrol,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    import muldiv_pkg::*;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;      // product accumulator, or {remainder, quotient}
    logic [2*XLEN-1:0] r_mcand;    // multiplicand, shifted left each step
    logic [XLEN-1:0]   r_opb;      // multiplier (shifted right) or divisor
    logic              r_is_div;
    logic              r_neg_res;  // product/quotient sign
    logic              r_neg_rem;  // remainder sign (dividend sign)

    logic              w_is_mul;
    logic              w_is_div;
    logic              w_signed;
    logic              w_div_zero;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_idle_cmd;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN:0]   w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;

    assign w_is_mul   = (alucontrol == OP_MULT) || (alucontrol == OP_MULTU);
    assign w_is_div   = (alucontrol == OP_DIV)  || (alucontrol == OP_DIVU);
    assign w_signed   = (alucontrol == OP_MULT) || (alucontrol == OP_DIV);
    assign w_div_zero = w_is_div && (srcb == '0);
    // A zero divisor runs as unsigned on the raw dividend: restoring division by
    // zero then naturally yields quotient all-ones and remainder = dividend.
    assign w_a_neg    = w_signed && srca[XLEN-1] && !w_div_zero;
    assign w_b_neg    = w_signed && srcb[XLEN-1];
    assign w_idle_cmd = (r_state == IDLE) && start && !flush;

    assign busy = (r_state != IDLE);

    muldiv_signfix #(.WIDTH(XLEN)) u_abs_a (
        .i_din  (srca),
        .i_neg  (w_a_neg),
        .o_dout (w_abs_a)
    );

    muldiv_signfix #(.WIDTH(XLEN)) u_abs_b (
        .i_din  (srcb),
        .i_neg  (w_b_neg),
        .o_dout (w_abs_b)
    );

    muldiv_signfix #(.WIDTH(2*XLEN)) u_fix_prod (
        .i_din  (r_acc),
        .i_neg  (r_neg_res),
        .o_dout (w_prod_fix)
    );

    muldiv_signfix #(.WIDTH(XLEN)) u_fix_quot (
        .i_din  (r_acc[XLEN-1:0]),
        .i_neg  (r_neg_res),
        .o_dout (w_quot_fix)
    );

    muldiv_signfix #(.WIDTH(XLEN)) u_fix_rem (
        .i_din  (r_acc[2*XLEN-1:XLEN]),
        .i_neg  (r_neg_rem),
        .o_dout (w_rem_fix)
    );

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    assign w_mul_next  = r_opb[0] ? (r_acc + r_mcand) : r_acc;
    assign w_div_shift = {r_acc, 1'b0};
    assign w_div_diff  = w_div_shift[2*XLEN:XLEN] - {1'b0, r_opb};
    assign w_div_next  = w_div_diff[XLEN] ? w_div_shift[2*XLEN-1:0]
                                          : {w_div_diff[XLEN-1:0], w_div_shift[XLEN-1:1], 1'b1};

    // Control FSM, iteration counter and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_opb     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_idle_cmd && (w_is_mul || w_is_div)) begin
                        r_is_div  <= w_is_div;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_opb     <= w_abs_b;
                        r_cnt     <= '0;
                        r_state   <= RUN;
                        if (w_is_div) begin
                            r_acc   <= {{XLEN{1'b0}}, w_abs_a};
                            r_mcand <= '0;
                        end else begin
                            r_acc   <= '0;
                            r_mcand <= {{XLEN{1'b0}}, w_abs_a};
`ifdef MULDIV_EARLY_OUT_EN
                            if (w_abs_b == '0) begin
                                r_state <= FIX;
                            end
`endif
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                        if (r_is_div) begin
                            r_acc <= w_div_next;
                        end else begin
                            r_acc   <= w_mul_next;
                            r_mcand <= {r_mcand[2*XLEN-2:0], 1'b0};
                            r_opb   <= {1'b0, r_opb[XLEN-1:1]};
                        end
                        if (r_cnt == c_last) begin
                            r_state <= FIX;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        else if (!r_is_div && (r_opb[XLEN-1:1] == '0)) begin
                            r_state <= FIX;
                        end
`endif
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Architectural HI/LO and the done pulse; results land whole from FIX only
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((r_state == FIX) && !flush) begin
                done <= 1'b1;
                if (r_is_div) begin
                    hi <= w_rem_fix;
                    lo <= w_quot_fix;
                end else begin
                    {hi, lo} <= w_prod_fix;
                end
            end else if (w_idle_cmd) begin
                if (alucontrol == OP_MTHI) begin
                    hi <= srca;
                end
                if (alucontrol == OP_MTLO) begin
                    lo <= srca;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: directed vector table,
//               hand-written corner sequences and randomized operations
//               checked against a 64-bit arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit c_early = 1'b1;
`else
    localparam bit c_early = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results from plain 64-bit arithmetic
    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        eh = '0;
        el = '0;
        case (op)
            OP_MULT:  begin sp = sa * sb; {eh, el} = sp; end
            OP_MULTU: begin up = ua * ub; {eh, el} = up; end
            OP_DIV: begin
                if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
                else begin sp = sa / sb; el = sp[31:0]; sp = sa % sb; eh = sp[31:0]; end
            end
            OP_DIVU: begin
                if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
                else begin up = ua / ub; el = up[31:0]; up = ua % ub; eh = up[31:0]; end
            end
            default: begin eh = '0; el = '0; end
        endcase
    endfunction

    // Cycle at which done is expected, counted from the start cycle
    function automatic int exp_latency(input logic [5:0] op, input logic [31:0] b);
        logic [31:0] mag;
        int          top;
        mag = (op == OP_MULT && b[31]) ? (~b + 32'd1) : b;
        top = -1;
        for (int i = 0; i < 32; i++) if (mag[i]) top = i;
        if (c_early && (op == OP_MULT || op == OP_MULTU)) return 3 + top;
        return 34;
    endfunction

    // Issue one mul/div op; optionally inject an illegal start while busy
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int junk_at, input string name);
        int lat, busy_cnt, done_at, k;
        lat = exp_latency(op, b);
        start = 1'b1; alucontrol = op; srca = a; srcb = b;
        tick();
        start = 1'b0; alucontrol = 6'h00; srca = $urandom; srcb = $urandom;
        busy_cnt = 0;
        done_at  = 0;
        k        = 1;
        while (done_at == 0 && k <= 60) begin
            if (k == junk_at)     begin start = 1'b1; alucontrol = OP_MTHI; end
            if (k == junk_at + 1) begin start = 1'b1; alucontrol = OP_DIVU; end
            if (busy) busy_cnt++;
            if (done) done_at = k;
            tick();
            start = 1'b0;
            k++;
        end
        check({name, ".latency"}, 64'(done_at), 64'(lat));
        check({name, ".busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
        check({name, ".hi"}, 64'(hi), 64'(eh));
        check({name, ".lo"}, 64'(lo), 64'(el));
        check({name, ".done_pulse"}, 64'({done, busy}), 64'(0));
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [31:0] ra, rb, eh, el;
        logic [5:0]  rop;
        int          seen;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000, 32'h5555_5555};
        vecs[8]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9]  = '{OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[10] = '{OP_MULTU, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000};

        reset_n = 1'b0; start = 1'b0; flush = 1'b0;
        alucontrol = 6'h00; srca = '0; srcb = '0;
        repeat (3) tick();
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.hi", 64'(hi), 64'(0));
        check("reset.lo", 64'(lo), 64'(0));
        reset_n = 1'b1;
        tick();

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0,
                   $sformatf("vec%0d", i));
        end

        // Starts while busy must be ignored
        run_op(OP_MULT, 32'h0001_2345, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFEDC_BB00, 5, "busy_start");

        // mthi then mtlo in consecutive cycles
        start = 1'b1; alucontrol = OP_MTHI; srca = 32'h0000_1234;
        tick();
        alucontrol = OP_MTLO; srca = 32'h0000_ABCD;
        check("mthi.hi", 64'(hi), 64'h1234);
        check("mthi.busy_done", 64'({busy, done}), 64'(0));
        tick();
        start = 1'b0;
        check("mtlo.lo", 64'(lo), 64'hABCD);
        check("mtlo.hi", 64'(hi), 64'h1234);
        check("mtlo.busy_done", 64'({busy, done}), 64'(0));
        m_hi = 32'h0000_1234;
        m_lo = 32'h0000_ABCD;

        // Unrecognized code does nothing
        start = 1'b1; alucontrol = 6'h20; srca = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        check("badop.state", 64'({busy, done}), 64'(0));
        check("badop.hilo", {hi, lo}, {m_hi, m_lo});

        // Flush in IDLE beats start
        start = 1'b1; flush = 1'b1; alucontrol = OP_MULT; srca = 32'd3; srcb = 32'd4;
        tick();
        check("idleflush.busy", 64'(busy), 64'(0));
        alucontrol = OP_MTLO; srca = 32'h5555_AAAA;
        tick();
        start = 1'b0; flush = 1'b0;
        check("idleflush.hilo", {hi, lo}, {m_hi, m_lo});

        // Flush at N+10 of a divu
        start = 1'b1; alucontrol = OP_DIVU; srca = 32'd1000; srcb = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush.busy", 64'(busy), 64'(0));
        seen = 0;
        repeat (40) begin
            if (done || busy) seen = 1;
            tick();
        end
        check("flush.no_done", 64'(seen), 64'(0));
        check("flush.hilo", {hi, lo}, {m_hi, m_lo});
        run_op(OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 0, "after_flush");

        // Reset at N+5 of a mult, with a start in the same cycle
        start = 1'b1; alucontrol = OP_MULT; srca = 32'd12345; srcb = 32'd678;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0; start = 1'b1;
        tick();
        check("midreset.outs", {30'd0, busy, done, hi, lo}, 64'(0));
        reset_n = 1'b1; start = 1'b0;
        m_hi = '0;
        m_lo = '0;
        tick();
        check("midreset.idle", 64'({busy, done}), 64'(0));

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: rop = OP_MULT;
                1: rop = OP_MULTU;
                2: rop = OP_DIV;
                default: rop = OP_DIVU;
            endcase
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(0, 40)) - 32'd20;
                2: rb = 32'h8000_0000 >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if (n % 5 == 0) ra = 32'h8000_0000;
            model(rop, ra, rb, eh, el);
            run_op(rop, ra, rb, eh, el, 0, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
